led_color_decoder: RTL
======================

LED_COLOR_DECODER -- requirements
Module: led_color_decoder

Interface
REQ-001 Parameter SAMPLE_DIV, 234, clk ticks between samples; legal range 2..65535.
REQ-002 Parameter N_SAMPLES, 255, samples per measurement window; fixed; sets 8-bit level range.
REQ-003 Port clk  in  1  system clock, 12 MHz on board.
REQ-004 Port rst  in  1  reset; one clock, reset is asynchronous and active-high.
REQ-005 Port en  in  1  decode enable; level-sensitive.
REQ-006 Port led_in  in  3  active-low RGB drive as sent to the LED: [2]=R, [1]=B, [0]=G; 3'b111 = off; asynchronous to clk.
REQ-007 Port r_level, g_level, b_level  out  8 each  on-sample count per channel in the last completed window.
REQ-008 Port dominant  out  3  led code held for the most samples in the last window.
REQ-009 Port multi_color  out  1  more than two distinct codes were seen in the last window.
REQ-010 Port level_valid  out  1  one-cycle pulse when the outputs above update.
REQ-011 Port locked  out  1  high while state is ACQUIRE or REPORT.

Function
REQ-012 led_in SHALL pass through a 2-flop synchronizer; sync flops reset to 3'b111; all logic uses the synced value.
REQ-013 FSM states SHALL be SYNC, ACQUIRE, REPORT; reset state SYNC.
REQ-014 SYNC: wait for any change of synced led vs. its previous-cycle value while en=1; next state ACQUIRE with tick counter and all window counters cleared.
REQ-015 ACQUIRE: tick counter runs 0..SAMPLE_DIV-1 and wraps; sample strobe fires when the counter equals SAMPLE_DIV-1.
REQ-016 On each strobe, each channel counter SHALL increment when its synced bit is 0; sample counter increments.
REQ-017 Color tracking on each strobe: slot A empty or code==A -> A count+1 (load A); else slot B empty or code==B -> B count+1 (load B); else set window multi flag.
REQ-018 The strobe that is sample N_SAMPLES SHALL be counted, then the FSM enters REPORT on the next cycle.
REQ-019 REPORT (exactly one cycle): latch levels, multi flag, dominant (A if countA >= countB, else B), and pulse level_valid; clear window counters and slots; return to ACQUIRE.
REQ-020 The tick counter SHALL keep running through REPORT, so window period is exactly SAMPLE_DIV*N_SAMPLES cycles, gapless.
REQ-021 Counters are 8 bits and cannot overflow (max 255); no saturation logic.
REQ-022 en=0 in ACQUIRE or REPORT: next state SYNC, partial window discarded, no level_valid, latched outputs held.
REQ-023 Latched outputs SHALL change only in REPORT.

Reset
REQ-024 rst SHALL asynchronously force: state SYNC; levels 0; dominant 3'b111; multi_color 0; level_valid 0; locked 0; all counters 0; slots empty.
REQ-025 rst asserted mid-window SHALL discard the window; after release a fresh led edge is required before ACQUIRE.

Structure
REQ-026 Shared package: LED code constants (OFF=3'b111, RED=3'b011, BLUE=3'b101, GREEN=3'b110), TICKS_PER_US=12, FSM state encoding.
REQ-027 One sub-module, led_sync3: 3-bit 2-flop synchronizer with async reset to OFF.

Verification (SAMPLE_DIV=4)
REQ-028 Reset held, led_in toggling -> all outputs at reset values, locked=0, no level_valid.
REQ-029 OFF then RED held, en=1 -> locked one cycle after the edge; level_valid after 1020 cycles; r=255, g=0, b=0, dominant=011, multi_color=0.
REQ-030 RED for 100 samples then BLUE for 155 samples -> r=100, b=155, g=0, dominant=101, multi_color=0; next level_valid exactly 1020 cycles later.
REQ-031 RED, BLUE, GREEN 85 samples each -> multi_color=1, dominant=011, r=85, b=85, g=85.
REQ-032 en dropped at sample 200 -> no level_valid, locked=0, outputs unchanged; en high plus new edge -> full window reported.
REQ-033 rst pulsed at sample 128 -> outputs return to reset values; the following window reports from the first post-reset edge only.

Source files
------------

// File: rtl/led_color_decoder_pkg.sv
// Shared constants and types for the LED color decoder.
package led_color_decoder_pkg;

   // Active-low RGB codes as driven onto the LED pins ([2]=R, [1]=B, [0]=G).
   localparam logic [2:0] LED_OFF   = 3'b111;
   localparam logic [2:0] LED_RED   = 3'b011;
   localparam logic [2:0] LED_BLUE  = 3'b101;
   localparam logic [2:0] LED_GREEN = 3'b110;

   // Board clock is 12 MHz.
   localparam int TICKS_PER_US = 12;

   typedef enum logic [1:0] {
      ST_SYNC    = 2'd0,
      ST_ACQUIRE = 2'd1,
      ST_REPORT  = 2'd2
   } state_t;

endpackage

// File: rtl/led_sync3.sv
// Two-flop synchronizer for the 3-bit LED drive; resets to the OFF code.
module led_sync3
   import led_color_decoder_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] d,
   output logic [2:0] q
);

   logic [2:0] meta;

   // Two-stage capture of the asynchronous LED drive.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= LED_OFF;
         q    <= LED_OFF;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/led_color_decoder.sv
// Measures per-channel on-time of an LED drive over fixed sample windows
// and reports levels, the dominant color and whether >2 colors appeared.
module led_color_decoder
   import led_color_decoder_pkg::*;
#(
   parameter int SAMPLE_DIV = 234,
   parameter int N_SAMPLES  = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [2:0] led_in,
   output logic [7:0] r_level,
   output logic [7:0] g_level,
   output logic [7:0] b_level,
   output logic [2:0] dominant,
   output logic       multi_color,
   output logic       level_valid,
   output logic       locked
);

   localparam logic [15:0] TICK_LAST   = 16'(SAMPLE_DIV - 1);
   localparam logic [7:0]  SAMPLE_LAST = 8'(N_SAMPLES - 1);

   state_t      state;
   state_t      state_next;
   logic [2:0]  led_sync;
   logic [2:0]  led_prev;
   logic [15:0] tick_cnt;
   logic [7:0]  sample_cnt;
   logic [7:0]  r_cnt;
   logic [7:0]  g_cnt;
   logic [7:0]  b_cnt;
   logic [2:0]  slot_a_code;
   logic [2:0]  slot_b_code;
   logic        slot_a_valid;
   logic        slot_b_valid;
   logic [7:0]  cnt_a;
   logic [7:0]  cnt_b;
   logic        multi_flag;
   logic        start_window;
   logic        strobe;
   logic        last_sample;
   logic        report_fire;

   led_sync3 u_sync (
      .clk (clk),
      .rst (rst),
      .d   (led_in),
      .q   (led_sync)
   );

   assign start_window = (state == ST_SYNC) && en && (led_sync != led_prev);
   assign strobe       = (state == ST_ACQUIRE) && (tick_cnt == TICK_LAST);
   assign last_sample  = strobe && (sample_cnt == SAMPLE_LAST);
   assign report_fire  = (state == ST_REPORT) && en;

   // Previous-cycle copy of the synced LED code, used for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) led_prev <= LED_OFF;
      else     led_prev <= led_sync;
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_SYNC;
      else     state <= state_next;
   end

   // Next-state logic: dropping en always abandons the window.
   always_comb begin
      state_next = state;
      case (state)
         ST_SYNC:    if (start_window) state_next = ST_ACQUIRE;
         ST_ACQUIRE: if (!en) state_next = ST_SYNC;
                     else if (last_sample) state_next = ST_REPORT;
         ST_REPORT:  if (!en) state_next = ST_SYNC;
                     else state_next = ST_ACQUIRE;
         default:    state_next = ST_SYNC;
      endcase
   end

   // Output decode from state.
   always_comb begin
      locked = (state == ST_ACQUIRE) || (state == ST_REPORT);
   end

   // Tick divider; keeps running through REPORT so windows are gapless.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_cnt <= '0;
      end else if (start_window) begin
         tick_cnt <= '0;
      end else if (state != ST_SYNC) begin
         if (tick_cnt == TICK_LAST) tick_cnt <= '0;
         else                       tick_cnt <= tick_cnt + 16'd1;
      end
   end

   // Window accumulation: channel counts and two-slot color tracking.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sample_cnt   <= '0;
         r_cnt        <= '0;
         g_cnt        <= '0;
         b_cnt        <= '0;
         slot_a_valid <= 1'b0;
         slot_b_valid <= 1'b0;
         slot_a_code  <= LED_OFF;
         slot_b_code  <= LED_OFF;
         cnt_a        <= '0;
         cnt_b        <= '0;
         multi_flag   <= 1'b0;
      end else if (start_window || (state == ST_REPORT)) begin
         sample_cnt   <= '0;
         r_cnt        <= '0;
         g_cnt        <= '0;
         b_cnt        <= '0;
         slot_a_valid <= 1'b0;
         slot_b_valid <= 1'b0;
         slot_a_code  <= LED_OFF;
         slot_b_code  <= LED_OFF;
         cnt_a        <= '0;
         cnt_b        <= '0;
         multi_flag   <= 1'b0;
      end else if (strobe) begin
         sample_cnt <= sample_cnt + 8'd1;
         if (!led_sync[2]) r_cnt <= r_cnt + 8'd1;
         if (!led_sync[1]) b_cnt <= b_cnt + 8'd1;
         if (!led_sync[0]) g_cnt <= g_cnt + 8'd1;
         if (!slot_a_valid || (led_sync == slot_a_code)) begin
            slot_a_valid <= 1'b1;
            slot_a_code  <= led_sync;
            cnt_a        <= cnt_a + 8'd1;
         end else if (!slot_b_valid || (led_sync == slot_b_code)) begin
            slot_b_valid <= 1'b1;
            slot_b_code  <= led_sync;
            cnt_b        <= cnt_b + 8'd1;
         end else begin
            multi_flag <= 1'b1;
         end
      end
   end

   // Result latch; level_valid is registered so it lines up with the new values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_level     <= '0;
         g_level     <= '0;
         b_level     <= '0;
         dominant    <= LED_OFF;
         multi_color <= 1'b0;
         level_valid <= 1'b0;
      end else begin
         level_valid <= 1'b0;
         if (report_fire) begin
            r_level     <= r_cnt;
            g_level     <= g_cnt;
            b_level     <= b_cnt;
            dominant    <= (cnt_a >= cnt_b) ? slot_a_code : slot_b_code;
            multi_color <= multi_flag;
            level_valid <= 1'b1;
         end
      end
   end

endmodule
